// File: rtl/fp_operand_swap_stage.sv
// Two-stage FP add/sub operand ordering: S1 feeds an external magnitude comparator,
// S2 registers the ordered pair, exponent difference, result sign and effective operation.
module fp_operand_swap_stage #(
    parameter int unsigned EW = 8,
    parameter int unsigned SW = 23
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EW+SW:0]       Data_X,
    input  logic [EW+SW:0]       Data_Y,
    input  logic                 add_subt,
    output logic [EW+SW-1:0]     cmp_a,
    output logic [EW+SW-1:0]     cmp_b,
    input  logic                 cmp_less,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EW+SW-1:0]     DMP,
    output logic [EW+SW-1:0]     DmP,
    output logic [EW-1:0]        exp_diff,
    output logic                 sign_result,
    output logic                 eff_sub,
    output logic                 swapped
);

    localparam int unsigned W  = 1 + EW + SW;
    localparam int unsigned MW = W - 1;

    logic          s1_valid_q;
    logic [W-1:0]  x_q, y_q;
    logic          op_q;

    logic          s2_valid_q;
    logic [MW-1:0] dmp_q, dmp_small_q;
    logic [EW-1:0] exp_diff_q;
    logic          sign_q, eff_sub_q, swapped_q;

    logic          s2_adv, s1_load, s2_load;
    logic          s1_valid_d, s2_valid_d;
    logic [MW-1:0] dmp_d, dmp_small_d;
    logic [EW-1:0] exp_diff_d;
    logic          sign_d, eff_sub_d, sy_eff, mag_eq;

    // Handshake: S2 advances whenever it is empty or being drained.
    always_comb begin
        s2_adv     = s1_valid_q & (~s2_valid_q | out_ready);
        in_ready   = ~s1_valid_q | s2_adv;
        s1_load    = in_valid & in_ready & ~flush;
        s2_load    = s2_adv & ~flush;
        s1_valid_d = (in_valid & in_ready) | (s1_valid_q & ~s2_adv);
        s2_valid_d = s2_adv | (s2_valid_q & ~out_ready);
    end

    // Ordering from the comparator result; equal magnitudes keep X as the larger.
    always_comb begin
        mag_eq      = (x_q[MW-1:0] == y_q[MW-1:0]);
        sy_eff      = y_q[W-1] ^ op_q;
        eff_sub_d   = x_q[W-1] ^ sy_eff;
        dmp_d       = cmp_less ? y_q[MW-1:0] : x_q[MW-1:0];
        dmp_small_d = cmp_less ? x_q[MW-1:0] : y_q[MW-1:0];
        exp_diff_d  = EW'(dmp_d[MW-1 -: EW] - dmp_small_d[MW-1 -: EW]);
        sign_d      = cmp_less ? sy_eff : x_q[W-1];
        if (eff_sub_d && mag_eq) begin
            sign_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            op_q       <= 1'b0;
        end else begin
            s1_valid_q <= flush ? 1'b0 : s1_valid_d;
            if (s1_load) begin
                x_q  <= Data_X;
                y_q  <= Data_Y;
                op_q <= add_subt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_valid_q  <= 1'b0;
            dmp_q       <= '0;
            dmp_small_q <= '0;
            exp_diff_q  <= '0;
            sign_q      <= 1'b0;
            eff_sub_q   <= 1'b0;
            swapped_q   <= 1'b0;
        end else begin
            s2_valid_q <= flush ? 1'b0 : s2_valid_d;
            if (s2_load) begin
                dmp_q       <= dmp_d;
                dmp_small_q <= dmp_small_d;
                exp_diff_q  <= exp_diff_d;
                sign_q      <= sign_d;
                eff_sub_q   <= eff_sub_d;
                swapped_q   <= cmp_less;
            end
        end
    end

    assign cmp_a       = x_q[MW-1:0];
    assign cmp_b       = y_q[MW-1:0];
    assign out_valid   = s2_valid_q;
    assign DMP         = dmp_q;
    assign DmP         = dmp_small_q;
    assign exp_diff    = exp_diff_q;
    assign sign_result = sign_q;
    assign eff_sub     = eff_sub_q;
    assign swapped     = swapped_q;

endmodule

// File: tb/tb_fp_operand_swap_stage.sv
// Directed bench for fp_operand_swap_stage: vector table plus backpressure and flush sequences.
module tb_fp_operand_swap_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] Data_X, Data_Y;
    logic        add_subt;
    logic [30:0] cmp_a, cmp_b;
    logic        cmp_less;
    logic        out_valid;
    logic        out_ready;
    logic [30:0] DMP, DmP;
    logic [7:0]  exp_diff;
    logic        sign_result, eff_sub, swapped;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // External magnitude comparator model
    assign cmp_less = (cmp_a < cmp_b);

    fp_operand_swap_stage #(.EW(8), .SW(23)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .Data_X(Data_X), .Data_Y(Data_Y), .add_subt(add_subt),
        .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_less(cmp_less),
        .out_valid(out_valid), .out_ready(out_ready),
        .DMP(DMP), .DmP(DmP), .exp_diff(exp_diff),
        .sign_result(sign_result), .eff_sub(eff_sub), .swapped(swapped)
    );

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic        op;
        logic        sw;
        logic [30:0] dmp;
        logic [30:0] dmps;
        logic [7:0]  ed;
        logic        es;
        logic        sg;
    } vec_t;

    vec_t tv[8];

    function automatic vec_t mk(logic [31:0] x, logic [31:0] y, logic op, logic sw,
                                logic [30:0] dmp, logic [30:0] dmps, logic [7:0] ed,
                                logic es, logic sg);
        vec_t v;
        v.x = x; v.y = y; v.op = op; v.sw = sw; v.dmp = dmp; v.dmps = dmps;
        v.ed = ed; v.es = es; v.sg = sg;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input int k);
        Data_X   = tv[k].x;
        Data_Y   = tv[k].y;
        add_subt = tv[k].op;
    endtask

    task automatic chk_out(input int k, input string tag);
        chk($sformatf("%s[%0d] swapped", tag, k), 64'(swapped), 64'(tv[k].sw));
        chk($sformatf("%s[%0d] DMP", tag, k), 64'(DMP), 64'(tv[k].dmp));
        chk($sformatf("%s[%0d] DmP", tag, k), 64'(DmP), 64'(tv[k].dmps));
        chk($sformatf("%s[%0d] exp_diff", tag, k), 64'(exp_diff), 64'(tv[k].ed));
        chk($sformatf("%s[%0d] eff_sub", tag, k), 64'(eff_sub), 64'(tv[k].es));
        chk($sformatf("%s[%0d] sign", tag, k), 64'(sign_result), 64'(tv[k].sg));
    endtask

    initial begin
        //           X             Y             op sw  DMP           DmP           ed     es sg
        tv[0] = mk(32'h40000000, 32'h40400000, 0, 1, 31'h40400000, 31'h40000000, 8'd0,   0, 0);
        tv[1] = mk(32'h41200000, 32'h3F800000, 1, 0, 31'h41200000, 31'h3F800000, 8'd3,   1, 0);
        tv[2] = mk(32'h40A00000, 32'h40A00000, 1, 0, 31'h40A00000, 31'h40A00000, 8'd0,   1, 0);
        tv[3] = mk(32'hC0A00000, 32'h40A00000, 0, 0, 31'h40A00000, 31'h40A00000, 8'd0,   1, 0);
        tv[4] = mk(32'hC0000000, 32'h40400000, 1, 1, 31'h40400000, 31'h40000000, 8'd0,   0, 1);
        tv[5] = mk(32'h3F800000, 32'hC1200000, 0, 1, 31'h41200000, 31'h3F800000, 8'd3,   1, 1);
        tv[6] = mk(32'h7F800000, 32'h00000000, 0, 0, 31'h7F800000, 31'h00000000, 8'd255, 0, 0);
        tv[7] = mk(32'h80000000, 32'h00000001, 0, 1, 31'h00000001, 31'h00000000, 8'd0,   1, 0);

        // Reset held with a valid input present
        rst = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        drive(5);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst in_ready", 64'(in_ready), 64'd1);
        chk("rst DMP", 64'(DMP), 64'd0);
        chk("rst DmP", 64'(DmP), 64'd0);
        chk("rst cmp_a", 64'(cmp_a), 64'd0);
        chk("rst cmp_b", 64'(cmp_b), 64'd0);
        chk("rst flags", 64'({exp_diff, sign_result, eff_sub, swapped}), 64'd0);
        in_valid = 1'b0;
        rst = 1'b1;

        // Table: one operand pair at a time, two-cycle latency
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            drive(k);
            in_valid = 1'b1;
            #1 chk($sformatf("tbl[%0d] in_ready", k), 64'(in_ready), 64'd1);
            @(negedge clk);
            in_valid = 1'b0;
            chk($sformatf("tbl[%0d] out_valid early", k), 64'(out_valid), 64'd0);
            @(negedge clk);
            chk($sformatf("tbl[%0d] out_valid", k), 64'(out_valid), 64'd1);
            chk_out(k, "tbl");
        end
        @(negedge clk);
        chk("drain out_valid", 64'(out_valid), 64'd0);

        // Backpressure: four pairs streamed, out_ready low for three cycles
        begin
            int idx_in = 0;
            int idx_out = 0;
            logic fire_in;
            for (int cyc = 0; cyc < 40 && idx_out < 4; cyc++) begin
                @(negedge clk);
                in_valid  = (idx_in < 4);
                if (idx_in < 4) drive(4 + idx_in);
                out_ready = !(cyc >= 2 && cyc < 5);
                #1;
                fire_in = in_valid && in_ready;
                if (cyc >= 2 && cyc < 5) begin
                    chk($sformatf("bp c%0d in_ready", cyc), 64'(in_ready), 64'd0);
                    chk($sformatf("bp c%0d accepts", cyc), 64'(idx_in), 64'd2);
                    chk($sformatf("bp c%0d out_valid", cyc), 64'(out_valid), 64'd1);
                    chk_out(4, "bp hold");
                end
                if (out_valid && out_ready) begin
                    chk_out(4 + idx_out, "bp out");
                    idx_out++;
                end
                @(posedge clk);
                if (fire_in) idx_in++;
            end
            chk("bp outputs seen", 64'(idx_out), 64'd4);
            @(negedge clk);
            in_valid = 1'b0;
            #1 chk("bp no dup", 64'(out_valid), 64'd0);
        end

        // Flush with both stages full and a new pair offered
        @(negedge clk);
        out_ready = 1'b0;
        drive(0); in_valid = 1'b1;
        @(negedge clk);
        drive(1);
        @(negedge clk);
        chk("fl pre out_valid", 64'(out_valid), 64'd1);
        chk("fl pre in_ready", 64'(in_ready), 64'd0);
        drive(2); flush = 1'b1; out_ready = 1'b1;
        #1 chk("fl offer in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("fl out_valid", 64'(out_valid), 64'd0);
        chk("fl in_ready", 64'(in_ready), 64'd1);
        chk("fl not captured", 64'(cmp_a), 64'(tv[1].x[30:0]));
        @(negedge clk);
        chk("fl stays empty", 64'(out_valid), 64'd0);
        drive(3); in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("fl post early", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("fl post out_valid", 64'(out_valid), 64'd1);
        chk_out(3, "fl post");
        @(negedge clk);
        chk("fl post drain", 64'(out_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
